// File: rtl/fb_pkg.sv
// Shared constants and state types for the framebuffer page scheduler.
// One page is 640x480 1-bpp pixels packed into 32-bit words.
package fb_pkg;

  localparam int WORDS_PER_PAGE = 9600;
  localparam int PAGE_STRIDE    = 16384;
  localparam int ADDR_W         = $clog2(2 * PAGE_STRIDE);
  localparam int OFFS_W         = ADDR_W - 1;

  localparam logic [OFFS_W-1:0] PAGE_WORDS = 14'd9600;
  localparam logic [OFFS_W-1:0] CNT_LAST   = 14'd9599;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_FILL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQ_ACK = 2'd3;

  typedef enum logic {C_IDLE, C_CLEAR}   clear_state_t;
  typedef enum logic {F_IDLE, F_PENDING} flip_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Hardware clear/fill engine: walks every word of one page, pausing on
// any cycle the host owns the RAM write port.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic              clk50,
  input  logic              reset,
  input  logic              start,
  input  logic              back_page,
  input  logic              stall,
  output logic              busy,
  output logic              req,
  output logic [ADDR_W-1:0] addr
);

  clear_state_t      state_q, state_d;
  logic [OFFS_W-1:0] cnt_q, cnt_d;
  logic              target_q, target_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          state_d  = C_CLEAR;
          cnt_d    = '0;
          target_d = back_page;
        end
      end
      C_CLEAR: begin
        // The counter parks on the last word instead of wrapping.
        if (!stall) begin
          if (cnt_q == CNT_LAST) begin
            state_d = C_IDLE;
          end else begin
            cnt_d = cnt_q + 14'd1;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q  <= C_IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign busy = (state_q == C_CLEAR);
  assign req  = busy;
  assign addr = {target_q, cnt_q};

endmodule

// File: rtl/fb_page_scheduler.sv
// Write-side controller for the double-buffered framebuffer: arbitrates host
// pixel writes against the clear engine and defers page flips to vsync.
module fb_page_scheduler
  import fb_pkg::*;
(
  input  logic              clk50,
  input  logic              reset,
  input  logic              pix_write,
  input  logic              pix_chipselect,
  input  logic [OFFS_W-1:0] pix_address,
  input  logic [31:0]       pix_writedata,
  input  logic              ctrl_write,
  input  logic              ctrl_read,
  input  logic [1:0]        ctrl_address,
  input  logic [31:0]       ctrl_writedata,
  output logic [31:0]       ctrl_readdata,
  input  logic              vga_vs,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [31:0]       fb_data,
  output logic              display_page,
  output logic              irq
);

  flip_state_t       flip_state_q, flip_state_d;
  logic              vs_q;
  logic              display_page_q, display_page_d;
  logic              irq_q, irq_d;
  logic [31:0]       fill_q, fill_d;
  logic              fb_wren_q, fb_wren_d;
  logic [ADDR_W-1:0] fb_wraddress_q, fb_wraddress_d;
  logic [31:0]       fb_data_q, fb_data_d;
  logic [31:0]       ctrl_readdata_q, ctrl_readdata_d;

  logic              host_wr;
  logic              clear_start;
  logic              flip_req;
  logic              vs_fall;
  logic              clear_busy;
  logic              eng_req;
  logic [ADDR_W-1:0] eng_addr;
  logic              flip_pending;

  always_comb begin
    host_wr     = pix_write && pix_chipselect && (pix_address < PAGE_WORDS);
    clear_start = ctrl_write && (ctrl_address == REG_CTRL) && ctrl_writedata[0];
    flip_req    = ctrl_write && (ctrl_address == REG_CTRL) && ctrl_writedata[1];
    vs_fall     = !vga_vs && vs_q;
  end

  fb_clear_engine u_clear (
    .clk50     (clk50),
    .reset     (reset),
    .start     (clear_start),
    .back_page (~display_page_q),
    .stall     (host_wr),
    .busy      (clear_busy),
    .req       (eng_req),
    .addr      (eng_addr)
  );

  // Write-port arbitration: the host always wins, the engine retries next cycle.
  always_comb begin
    fb_wren_d      = 1'b0;
    fb_wraddress_d = fb_wraddress_q;
    fb_data_d      = fb_data_q;
    if (host_wr) begin
      fb_wren_d      = 1'b1;
      fb_wraddress_d = {~display_page_q, pix_address};
      fb_data_d      = pix_writedata;
    end else if (eng_req) begin
      fb_wren_d      = 1'b1;
      fb_wraddress_d = eng_addr;
      fb_data_d      = fill_q;
    end
  end

  // Flip waits for a vsync falling edge seen while no clear is running.
  always_comb begin
    flip_state_d   = flip_state_q;
    display_page_d = display_page_q;
    irq_d          = irq_q;
    if (ctrl_write && (ctrl_address == REG_IRQ_ACK)) begin
      irq_d = 1'b0;
    end
    case (flip_state_q)
      F_IDLE: begin
        if (flip_req) flip_state_d = F_PENDING;
      end
      F_PENDING: begin
        if (vs_fall && !clear_busy) begin
          flip_state_d   = F_IDLE;
          display_page_d = ~display_page_q;
          irq_d          = 1'b1;
        end
      end
      default: flip_state_d = F_IDLE;
    endcase
  end

  assign flip_pending = (flip_state_q == F_PENDING);

  always_comb begin
    fill_d          = fill_q;
    ctrl_readdata_d = ctrl_readdata_q;
    if (ctrl_write && (ctrl_address == REG_FILL)) begin
      fill_d = ctrl_writedata;
    end
    if (ctrl_read) begin
      case (ctrl_address)
        REG_FILL:   ctrl_readdata_d = fill_q;
        REG_STATUS: ctrl_readdata_d = {28'd0, irq_q, display_page_q,
                                       flip_pending, clear_busy};
        default:    ctrl_readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      flip_state_q    <= F_IDLE;
      vs_q            <= 1'b1;
      display_page_q  <= 1'b0;
      irq_q           <= 1'b0;
      fill_q          <= '0;
      fb_wren_q       <= 1'b0;
      fb_wraddress_q  <= '0;
      fb_data_q       <= '0;
      ctrl_readdata_q <= '0;
    end else begin
      flip_state_q    <= flip_state_d;
      vs_q            <= vga_vs;
      display_page_q  <= display_page_d;
      irq_q           <= irq_d;
      fill_q          <= fill_d;
      fb_wren_q       <= fb_wren_d;
      fb_wraddress_q  <= fb_wraddress_d;
      fb_data_q       <= fb_data_d;
      ctrl_readdata_q <= ctrl_readdata_d;
    end
  end

  assign fb_wren       = fb_wren_q;
  assign fb_wraddress  = fb_wraddress_q;
  assign fb_data       = fb_data_q;
  assign display_page  = display_page_q;
  assign irq           = irq_q;
  assign ctrl_readdata = ctrl_readdata_q;

endmodule
